// File: rtl/shift_unit_arbiter_pkg.sv
// Shared definitions for the shift-unit arbiter: op encodings, datapath widths,
// result-stage states and the bit-reverse helper used to build SLL.
package shift_unit_arbiter_pkg;

    localparam int SHIFT_W = 32;
    localparam int AMT_W   = 5;

    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    function automatic logic [SHIFT_W-1:0] bit_rev(input logic [SHIFT_W-1:0] x);
        logic [SHIFT_W-1:0] r;
        for (int i = 0; i < SHIFT_W; i++) begin
            r[i] = x[SHIFT_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/right_barrel_shifter.sv
// Logarithmic logical right shifter; one mux stage per amount bit.
module right_barrel_shifter #(
    parameter int W  = 32,
    parameter int AW = 5
) (
    input  logic [W-1:0]  data,
    input  logic [AW-1:0] amt,
    output logic [W-1:0]  result
);

    logic [W-1:0] stage [AW+1];

    always_comb begin
        stage[0] = data;
        for (int s = 0; s < AW; s++) begin
            stage[s+1] = amt[s] ? (stage[s] >> (1 << s)) : stage[s];
        end
        result = stage[AW];
    end

endmodule

// File: rtl/shift_unit_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter: one-hot grant from the valid vector and an
// internal last-granted pointer that only moves on an accepted grant.
module rr_arbiter_2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last;

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Reset to "requester 1 last" so requester 0 wins the first tie.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/shift_unit_arbiter.sv
// Shares one right barrel shifter between two requesters (SRL/SLL/SRA) with
// round-robin arbitration and a single registered result stage.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | result register empty, resp_valid = 0
//   ST_FULL  | result register holds a result, resp_valid = 1
module shift_unit_arbiter
    import shift_unit_arbiter_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int CNT_W = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*SHIFT_W-1:0] req_data,
    input  logic [NREQ*AMT_W-1:0]   req_amt,
    input  logic [NREQ*2-1:0]       req_op,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [SHIFT_W-1:0]      resp_data,
    output logic                    resp_id,
    output logic [NREQ*CNT_W-1:0]   acc_count
);

    state_t               state;
    logic [NREQ-1:0]      grant;
    logic                 gid;
    logic                 free;
    logic                 accept;
    logic [SHIFT_W-1:0]   op_x;
    logic [AMT_W-1:0]     op_amt;
    logic [1:0]           op_sel;
    logic [SHIFT_W-1:0]   sh_in;
    logic [SHIFT_W-1:0]   sh_out;
    logic [SHIFT_W-1:0]   sra_mask;
    logic [SHIFT_W-1:0]   result;
    logic [CNT_W-1:0]     cnt [NREQ];

    assign resp_valid = (state == ST_FULL);
    assign free       = ~resp_valid | resp_ready;

    rr_arbiter_2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .valid  (req_valid),
        .accept (accept),
        .grant  (grant)
    );

    // Handshake depends only on valids and the result-stage state, never on data.
    assign req_ready = grant & {NREQ{free}};
    assign accept    = |req_ready;
    assign gid       = grant[1];

    assign op_x   = gid ? req_data[2*SHIFT_W-1:SHIFT_W] : req_data[SHIFT_W-1:0];
    assign op_amt = gid ? req_amt[2*AMT_W-1:AMT_W]      : req_amt[AMT_W-1:0];
    assign op_sel = gid ? req_op[3:2]                   : req_op[1:0];

    assign sh_in = (op_sel == OP_SLL) ? bit_rev(op_x) : op_x;

    right_barrel_shifter #(
        .W  (SHIFT_W),
        .AW (AMT_W)
    ) u_shifter (
        .data   (sh_in),
        .amt    (op_amt),
        .result (sh_out)
    );

    assign sra_mask = op_x[SHIFT_W-1] ? ~({SHIFT_W{1'b1}} >> op_amt) : '0;

    always_comb begin
        result = sh_out;
        case (op_sel)
            OP_SLL:  result = bit_rev(sh_out);
            OP_SRA:  result = sh_out | sra_mask;
            default: result = sh_out;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_EMPTY;
            resp_data <= '0;
            resp_id   <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            case (state)
                ST_EMPTY: if (accept) state <= ST_FULL;
                ST_FULL:  if (resp_ready && !accept) state <= ST_EMPTY;
                default:  state <= ST_EMPTY;
            endcase
            if (accept) begin
                resp_data <= result;
                resp_id   <= gid;
                cnt[gid]  <= cnt[gid] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        acc_count = '0;
        for (int i = 0; i < NREQ; i++) begin
            acc_count[i*CNT_W +: CNT_W] = cnt[i];
        end
    end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed bench for shift_unit_arbiter: ops, round-robin, hold, async reset, counter wrap.
module tb_shift_unit_arbiter;

    logic        clock;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_data;
    logic [9:0]  req_amt;
    logic [3:0]  req_op;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_id;
    logic [31:0] acc_count;

    int total;
    int bad;

    shift_unit_arbiter #(.NREQ(2), .CNT_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_amt    (req_amt),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .acc_count  (acc_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic set_req(input int id, input logic [31:0] d, input logic [4:0] a,
                           input logic [1:0] op);
        if (id == 0) begin
            req_data[31:0] = d;
            req_amt[4:0]   = a;
            req_op[1:0]    = op;
        end else begin
            req_data[63:32] = d;
            req_amt[9:5]    = a;
            req_op[3:2]     = op;
        end
    endtask

    // Drives one request from a single requester; returns at the negedge after its accept.
    task automatic issue(input int id, input logic [31:0] d, input logic [4:0] a,
                         input logic [1:0] op);
        @(negedge clock);
        set_req(id, d, a, op);
        req_valid     = 2'b00;
        req_valid[id] = 1'b1;
        resp_ready    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge clock);
        req_valid  = 2'b00;
        resp_ready = 1'b0;
        reset      = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        req_valid  = 2'b00;
        req_data   = '0;
        req_amt    = '0;
        req_op     = '0;
        resp_ready = 1'b0;
        #12;
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
        total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", resp_data); end
        total++; if (resp_id !== 1'b0) begin bad++; $display("FAIL reset_id got=%b exp=0", resp_id); end
        total++; if (acc_count !== 32'h0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", acc_count); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_srl();
        @(negedge clock);
        set_req(0, 32'h8000_0000, 5'd4, 2'b00);
        req_valid  = 2'b01;
        resp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL srl_ready got=%b exp=01", req_ready); end
        @(posedge clock);
        @(negedge clock);
        req_valid = 2'b00;
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL srl_valid got=%b exp=1", resp_valid); end
        total++; if (resp_data !== 32'h0800_0000) begin bad++; $display("FAIL srl_data got=%h exp=08000000", resp_data); end
        total++; if (resp_id !== 1'b0) begin bad++; $display("FAIL srl_id got=%b exp=0", resp_id); end
        total++; if (acc_count[15:0] !== 16'd1) begin bad++; $display("FAIL srl_cnt0 got=%h exp=1", acc_count[15:0]); end
    endtask

    task automatic test_ops();
        logic [31:0] d  [7] = '{32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001,
                                32'h8000_0001, 32'h4000_0000, 32'h8000_0000};
        logic [4:0]  a  [7] = '{5'd31, 5'd31, 5'd0, 5'd0, 5'd0, 5'd4, 5'd1};
        logic [1:0]  op [7] = '{2'b10, 2'b01, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11};
        logic [31:0] ex [7] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0001, 32'h8000_0001,
                                32'h8000_0001, 32'h0400_0000, 32'h4000_0000};
        for (int i = 0; i < 7; i++) begin
            issue(1, d[i], a[i], op[i]);
            total++; if (resp_data !== ex[i]) begin bad++; $display("FAIL op_data[%0d] got=%h exp=%h", i, resp_data, ex[i]); end
            total++; if (resp_id !== 1'b1) begin bad++; $display("FAIL op_id[%0d] got=%b exp=1", i, resp_id); end
        end
        total++; if (acc_count !== 32'h0007_0001) begin bad++; $display("FAIL op_cnt got=%h exp=00070001", acc_count); end
    endtask

    task automatic test_round_robin();
        logic        g;
        logic [31:0] exd;
        do_reset();
        @(negedge clock);
        set_req(0, 32'h0000_00F0, 5'd4, 2'b00);
        set_req(1, 32'h0000_000F, 5'd4, 2'b01);
        req_valid  = 2'b11;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            g   = i[0];
            exd = g ? 32'h0000_00F0 : 32'h0000_000F;
            #1;
            total++; if (req_ready !== (g ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rr_ready[%0d] got=%b exp_grant=%b", i, req_ready, g); end
            @(posedge clock);
            @(negedge clock);
            total++; if (resp_id !== g) begin bad++; $display("FAIL rr_id[%0d] got=%b exp=%b", i, resp_id, g); end
            total++; if (resp_data !== exd) begin bad++; $display("FAIL rr_data[%0d] got=%h exp=%h", i, resp_data, exd); end
        end
        req_valid = 2'b00;
        total++; if (acc_count !== 32'h0002_0002) begin bad++; $display("FAIL rr_cnt got=%h exp=00020002", acc_count); end
    endtask

    task automatic test_back_to_back_hold();
        @(negedge clock);
        req_valid  = 2'b11;
        resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL hold_ready[%0d] got=%b exp=00", i, req_ready); end
            total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d] got=%b exp=1", i, resp_valid); end
            total++; if (resp_data !== 32'h0000_000F) begin bad++; $display("FAIL hold_data[%0d] got=%h exp=0000000f", i, resp_data); end
            total++; if (resp_id !== 1'b0) begin bad++; $display("FAIL hold_id[%0d] got=%b exp=0", i, resp_id); end
            if (i < 3) begin
                @(posedge clock);
                @(negedge clock);
            end
        end
        resp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL b2b_ready got=%b exp=10", req_ready); end
        @(posedge clock);
        @(negedge clock);
        req_valid = 2'b00;
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", resp_valid); end
        total++; if (resp_id !== 1'b1) begin bad++; $display("FAIL b2b_id got=%b exp=1", resp_id); end
        total++; if (resp_data !== 32'h0000_00F0) begin bad++; $display("FAIL b2b_data got=%h exp=000000f0", resp_data); end
        @(posedge clock);
        @(negedge clock);
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", resp_valid); end
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        set_req(1, 32'h1234_5678, 5'd0, 2'b00);
        req_valid  = 2'b10;
        resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid  = 2'b00;
        resp_ready = 1'b0;
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL ar_pre_valid got=%b exp=1", resp_valid); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", resp_valid); end
        total++; if (acc_count !== 32'h0) begin bad++; $display("FAIL ar_cnt got=%h exp=0", acc_count); end
        @(negedge clock);
        reset = 1'b1;
        req_valid  = 2'b11;
        resp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL ar_tie got=%b exp=01", req_ready); end
        @(posedge clock);
        @(negedge clock);
        req_valid = 2'b00;
        total++; if (resp_id !== 1'b0) begin bad++; $display("FAIL ar_id got=%b exp=0", resp_id); end
    endtask

    task automatic test_wrap();
        do_reset();
        issue(1, 32'h0000_0001, 5'd0, 2'b00);
        issue(1, 32'h0000_0002, 5'd0, 2'b00);
        @(negedge clock);
        set_req(0, 32'h0000_0010, 5'd1, 2'b00);
        req_valid  = 2'b01;
        resp_ready = 1'b1;
        repeat (65535) @(posedge clock);
        #1;
        req_valid = 2'b00;
        @(negedge clock);
        total++; if (acc_count[15:0] !== 16'hFFFF) begin bad++; $display("FAIL wrap_pre0 got=%h exp=ffff", acc_count[15:0]); end
        issue(0, 32'h0000_0010, 5'd1, 2'b00);
        total++; if (acc_count[15:0] !== 16'h0000) begin bad++; $display("FAIL wrap_cnt0 got=%h exp=0000", acc_count[15:0]); end
        total++; if (acc_count[31:16] !== 16'd2) begin bad++; $display("FAIL wrap_cnt1 got=%h exp=0002", acc_count[31:16]); end
        total++; if (resp_data !== 32'h0000_0008) begin bad++; $display("FAIL wrap_data got=%h exp=00000008", resp_data); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_srl();
        test_ops();
        test_round_robin();
        test_back_to_back_hold();
        test_async_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_unit_arbiter.md
Name: shift_unit_arbiter

Overview:
- Shares one `right_barrel_shifter` instance between two requesters, e.g. the ALU issue port and the multdiv sequencer.
- Each request is an SRL, SLL or SRA operation.
- SLL is formed by bit-reversing around the right shifter. SRA is formed by OR-ing a sign mask onto the shifted value.
- Round-robin arbitration, valid/ready handshake on every channel, one registered result stage.

Parameters:
- NREQ, 2, number of requesters; fixed at 2 in this revision.
- CNT_W, 16, width of each per-requester accept counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_ready  out  2  per-requester accept.
- req_data  in  64  operand; requester i uses bits [32i+31:32i].
- req_amt  in  10  shift amount; requester i uses bits [5i+4:5i].
- req_op  in  4  operation; requester i uses bits [2i+1:2i]. 00 = SRL, 01 = SLL, 10 = SRA, 11 = reserved (treated as SRL).
- resp_valid  out  1  result register holds a valid result.
- resp_ready  in  1  downstream accepts the result.
- resp_data  out  32  shift result.
- resp_id  out  1  index of the requester that issued the result.
- acc_count  out  2*CNT_W  per-requester accepted-request counters, wrapping.

Behaviour:
- Reset (reset low, asynchronous):
  - resp_valid=0, resp_data=0, resp_id=0, acc_count=0.
  - Round-robin pointer set to "requester 1 last granted", so requester 0 wins the first tie.
  - Reset asserted mid-transfer drops the held result; no response is issued for it.
- Stage free: `free = ~resp_valid | resp_ready`.
- Grant:
  - One requester valid: that requester is granted.
  - Both valid: the requester not last granted is granted.
  - Neither valid: no grant.
  - `req_ready[g] = free & req_valid[g]` for the granted g only. `req_ready` of the non-granted requester is 0.
  - `req_ready` is combinational from req_valid, resp_valid and resp_ready; there is no path from data inputs.
- Accept occurs when `req_valid[g] & req_ready[g]` is high at a clock edge. On accept:
  - Result register loads the computed value; resp_id <= g; resp_valid <= 1.
  - Pointer records g as last granted.
  - acc_count[g] increments modulo 2^CNT_W.
- Latency: a request accepted at edge N presents its result from edge N until the edge at which it is consumed (`resp_valid & resp_ready`). Throughput is one result per cycle while resp_ready stays high.
- Back-to-back: consume and accept in the same edge is legal. The register reloads and resp_valid stays 1.
- Consume without a new accept: resp_valid <= 0. resp_data keeps its last value; it is don't-care when resp_valid is 0.
- Hold: while `resp_valid & ~resp_ready`, resp_data, resp_id and resp_valid are held stable and both req_ready bits are 0.
- Pointer: updates only on accept. A requester that deasserts before being accepted forfeits nothing.
- Datapath (combinational before the result register):
  - SRL: `shifter(x, amt)`.
  - SLL: `rev(shifter(rev(x), amt))`, where rev is 32-bit bit reversal.
  - SRA: `shifter(x, amt) | (x[31] ? ~(32'hFFFFFFFF >> amt) : 0)`.
  - amt = 0 returns x for every op.
- Fixed-state FSM via resp_valid: EMPTY (resp_valid=0) and FULL (resp_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on consume without accept.
  - FULL -> FULL on hold, or on consume with accept.

Decomposition:
- Shared package holds:
  - Op encodings: OP_SRL=2'b00, OP_SLL=2'b01, OP_SRA=2'b10.
  - SHIFT_W=32 and AMT_W=5.
  - The bit-reverse function.
- One sub-module is natural: `rr_arbiter_2`. It takes the valid vector, the pointer and the accept strobe, and produces a one-hot grant plus the pointer register.
- The `right_barrel_shifter` instance and the SLL/SRA wrapping logic stay in the top module.

Test Plan:
- Reset, then requester 0 sends data=0x80000000, amt=4, op=SRL, with resp_ready=1 → req_ready[0]=1 that cycle. On the next cycle resp_valid=1, resp_data=0x08000000, resp_id=0, and acc_count[0]=1.
- Requester 1 sends data=0x80000001, amt=31, op=SRA → resp_data=0xFFFFFFFF. The same data with op=SLL and amt=31 → 0x80000000. amt=0 with any op → 0x80000001.
- Both requesters valid continuously, resp_ready=1 → grants go 0,1,0,1 for 4 cycles; the resp_id sequence matches; each acc_count ends at 2.
- Accept one request, then hold resp_ready=0 for 3 cycles while both requesters are valid → resp_data and resp_id stay stable and req_ready=00 throughout. Raise resp_ready → consume and a new accept occur on the same edge, and resp_valid stays 1.
- Assert reset (low) while resp_valid=1 with resp_ready=0 → resp_valid drops immediately without waiting for a clock edge. Both counters read 0. After reset releases, the first tie goes to requester 0.
- Preload acc_count[0] to 0xFFFF via 65535 accepts → the next accept wraps acc_count[0] to 0x0000, and acc_count[1] is unchanged.
